// File: rtl/divider_unit.sv
// Multi-cycle RV32M divide/remainder unit: 32-step radix-2 restoring divider with register-file writeback.
// Optional macro DIVIDER_FASTPATH_EN sends divide-by-zero and signed overflow straight from IDLE to DONE.
module divider_unit (
    input  logic        i_clk,
    input  logic        i_arst_n,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    input  logic [4:0]  i_rd,
    output logic        o_busy,
    output logic        o_writeEnable,
    output logic [4:0]  o_writeAddress,
    output logic [31:0] o_writeData
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [4:0]  rd_q, rd_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        zero_q, zero_d;
    logic        ovf_q, ovf_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  waddr_q, waddr_d;

    // Operand decode for the request presented in IDLE
    logic        signed_in;
    logic        a_neg_in, b_neg_in;
    logic [31:0] a_mag_in, b_mag_in;
    logic        zero_in, ovf_in, fast_in;

    assign signed_in = ~i_op[0];
    assign a_neg_in  = signed_in & i_dividend[31];
    assign b_neg_in  = signed_in & i_divisor[31];
    assign a_mag_in  = a_neg_in ? (32'd0 - i_dividend) : i_dividend;
    assign b_mag_in  = b_neg_in ? (32'd0 - i_divisor) : i_divisor;
    assign zero_in   = (i_divisor == 32'd0);
    assign ovf_in    = signed_in && (i_dividend == 32'h8000_0000) && (i_divisor == 32'hFFFF_FFFF);

`ifdef DIVIDER_FASTPATH_EN
    assign fast_in = zero_in | ovf_in;
`else
    assign fast_in = 1'b0;
`endif

    // Architected results for the two corner cases; the long path uses the same override
    function automatic logic [31:0] special_result(input logic [1:0] op, input logic is_zero,
                                                   input logic [31:0] dividend);
        logic [31:0] res;
        if (is_zero) res = op[1] ? dividend : 32'hFFFF_FFFF;
        else         res = op[1] ? 32'd0    : 32'h8000_0000;
        return res;
    endfunction

    // One restoring step: shift in the next dividend bit, subtract if it fits
    logic [32:0] shifted, trial;
    logic        fits;
    logic [31:0] rem_step, quo_step;
    logic [31:0] quo_signed, rem_signed, final_res;

    assign shifted  = {rem_q, quo_q[31]};
    assign trial    = shifted - {1'b0, divisor_q};
    assign fits     = ~trial[32];
    assign rem_step = fits ? trial[31:0] : shifted[31:0];
    assign quo_step = {quo_q[30:0], fits};

    assign quo_signed = neg_quo_q ? (32'd0 - quo_step) : quo_step;
    assign rem_signed = neg_rem_q ? (32'd0 - rem_step) : rem_step;
    assign final_res  = (zero_q || ovf_q) ? special_result(op_q, zero_q, dividend_q)
                                          : (op_q[1] ? rem_signed : quo_signed);

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (i_start) state_d = fast_in ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (count_q == 5'd31) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_busy         = (state_q != S_IDLE);
        o_writeEnable  = (state_q == S_DONE) && (waddr_q != 5'd0);
        o_writeAddress = waddr_q;
        o_writeData    = wdata_q;
    end

    // Datapath next-state
    always_comb begin
        count_d    = count_q;
        op_d       = op_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        rd_d       = rd_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        wdata_d    = wdata_q;
        waddr_d    = waddr_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    count_d    = 5'd0;
                    op_d       = i_op;
                    dividend_d = i_dividend;
                    divisor_d  = b_mag_in;
                    rem_d      = 32'd0;
                    quo_d      = a_mag_in;
                    rd_d       = i_rd;
                    neg_quo_d  = a_neg_in ^ b_neg_in;
                    neg_rem_d  = a_neg_in;
                    zero_d     = zero_in;
                    ovf_d      = ovf_in;
                    if (fast_in) begin
                        wdata_d = special_result(i_op, zero_in, i_dividend);
                        waddr_d = i_rd;
                    end
                end
            end
            S_DIVIDE: begin
                rem_d   = rem_step;
                quo_d   = quo_step;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    wdata_d = final_res;
                    waddr_d = rd_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            count_q    <= 5'd0;
            op_q       <= 2'd0;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            rd_q       <= 5'd0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wdata_q    <= 32'd0;
            waddr_q    <= 5'd0;
        end else begin
            count_q    <= count_d;
            op_q       <= op_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            rd_q       <= rd_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            wdata_q    <= wdata_d;
            waddr_q    <= waddr_d;
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: driver pushes reference results, negedge monitor pops on each write strobe.
module tb_divider_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dvd, dvs;
    logic [4:0]  rd;
    logic        busy, we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    divider_unit dut (
        .i_clk          (clk),
        .i_arst_n       (rst_n),
        .i_start        (start),
        .i_op           (op),
        .i_dividend     (dvd),
        .i_divisor      (dvs),
        .i_rd           (rd),
        .o_busy         (busy),
        .o_writeEnable  (we),
        .o_writeAddress (waddr),
        .o_writeData    (wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: RISC-V M-extension semantics with plain integer arithmetic
    function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa, sbv;
        logic ovf;
        sa  = a;
        sbv = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            2'd0:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sbv));
            2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2:    return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sbv));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic special;
        special = (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIVIDER_FASTPATH_EN
        return special ? 1 : 33;
`else
        return special ? 33 : 33;
`endif
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'($urandom_range(0, 20));
            2:       return 32'd0 - 32'($urandom_range(1, 20));
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one request at a negedge; optionally pulse a stray start `glitch` cycles into the operation
    task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input int glitch);
        logic [31:0] exp_data;
        int lat, cnt;
        exp_data = model(f, a, b);
        lat      = latency(f, a, b);
        op = f; dvd = a; dvs = b; rd = r; start = 1'b1;
        if (r != 5'd0) sb.push_back('{r, exp_data, cyc + lat});
        $display("op=%0d a=%h b=%h rd=%0d expect=%h lat=%0d", f, a, b, r, exp_data, lat);
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            if (cnt == glitch) begin
                start = 1'b1; dvd = $urandom; dvs = 32'd3; rd = 5'd31; op = 2'd1;
            end else begin
                start = 1'b0;
            end
            cnt++;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (cnt != lat) begin
            errors++;
            $display("FAIL busy_len op=%0d actual=%0d required=%0d", f, cnt, lat);
        end
        checks++;
        if (wdata !== exp_data) begin
            errors++;
            $display("FAIL data_hold op=%0d actual=%h required=%h", f, wdata, exp_data);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && we) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual addr=%0d data=%h required none", waddr, wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (waddr !== e.rd || wdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write actual addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                             waddr, wdata, cyc, e.rd, e.data, e.cyc);
                end
            end
        end
    end

    task automatic check_zero_outputs(input string name);
        checks++;
        if (busy !== 1'b0 || we !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin
            errors++;
            $display("FAIL %s actual busy=%b we=%b addr=%0d data=%h required all zero",
                     name, busy, we, waddr, wdata);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'd0; dvd = 32'd0; dvs = 32'd0; rd = 5'd0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset_state");
        rst_n = 1'b1;

        // Directed cases; first request lands on the first edge after reset release
        do_op(2'd1, 32'd100, 32'd7, 5'd5, -1);
        do_op(2'd3, 32'd100, 32'd7, 5'd5, -1);
        do_op(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd6, -1);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd7, -1);
        do_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, -1);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, -1);
        do_op(2'd1, 32'd5, 32'd0, 5'd10, -1);
        do_op(2'd3, 32'd5, 32'd0, 5'd11, -1);
        do_op(2'd0, 32'hFFFF_FFF0, 32'd0, 5'd12, -1);
        do_op(2'd2, 32'hFFFF_FFF0, 32'd0, 5'd13, -1);
        do_op(2'd1, 32'hFFFF_FFFF, 32'd1, 5'd14, -1);
        do_op(2'd0, 32'd77, 32'hFFFF_FFF5, 5'd15, 10);
        do_op(2'd1, 32'd1000, 32'd9, 5'd0, -1);

        // Reset mid-operation: outputs clear immediately and no write follows
        op = 2'd1; dvd = 32'd1234; dvs = 32'd5; rd = 5'd20; start = 1'b1;
        $display("op=1 a=%h b=%h rd=20 aborted by reset", dvd, dvs);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2'd3, 32'd1234, 32'd5, 5'd21, -1);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom_range(0, 3)), rand_val(), rand_val(), 5'($urandom_range(0, 31)), -1);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_writes actual=%0d outstanding required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-002 i_clk  input  1  clock; all state updates on the rising edge.
REQ-003 i_arst_n  input  1  asynchronous active-low reset.
REQ-004 i_start  input  1  request a new division; sampled only in IDLE.
REQ-005 i_op  input  2  operation select; equals funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 i_dividend  input  32  rs1 operand.
REQ-007 i_divisor  input  32  rs2 operand.
REQ-008 i_rd  input  5  destination register index.
REQ-009 o_busy  output  1  high while an operation is in flight; the core stalls on it.
REQ-010 o_writeEnable  output  1  one-cycle register-file write strobe.
REQ-011 o_writeAddress  output  5  register-file write index, the captured i_rd.
REQ-012 o_writeData  output  32  quotient or remainder.

Function
REQ-013 SHALL implement the states IDLE, DIVIDE and DONE.
REQ-014 In IDLE with i_start=1, SHALL capture i_op, both operands and i_rd, and enter DIVIDE; i_start=0 stays IDLE.
REQ-015 Inputs SHALL be ignored in DIVIDE and DONE; i_start while busy is dropped and is not queued.
REQ-016 DIVIDE SHALL run exactly 32 cycles of radix-2 restoring division on 32-bit magnitudes, tracked by a 5-bit counter, then go to DONE.
REQ-017 Signed ops SHALL divide |a| by |b|, negate the quotient when the operand signs differ, and give the remainder the sign of the dividend.
REQ-018 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = dividend, for both signed and unsigned ops.
REQ-019 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-020 DONE SHALL last exactly one cycle, drive o_writeData, and return to IDLE on the next edge.
REQ-021 o_writeEnable SHALL be high only in DONE, and SHALL be suppressed when the captured rd = 0.
REQ-022 o_busy SHALL be high in DIVIDE and DONE, and low in IDLE.
REQ-023 Base latency: start sampled at edge t, DONE in cycle t+33, next start accepted at edge t+34.
REQ-024 o_writeData and o_writeAddress SHALL hold their last values outside DONE.

Reset
REQ-025 Reset low SHALL immediately force IDLE and o_busy=0, o_writeEnable=0, o_writeAddress=0, o_writeData=0, and clear the counter.
REQ-026 A reset during DIVIDE or DONE SHALL abandon the operation with no write strobe.
REQ-027 Reset deassertion SHALL need no extra cycles: i_start is accepted on the first rising edge after deassertion.

Configuration
REQ-028 Macro DIVIDER_FASTPATH_EN, when defined, SHALL route divide-by-zero and signed overflow from IDLE straight to DONE, so DONE occurs in cycle t+1.
REQ-029 Without DIVIDER_FASTPATH_EN, these cases SHALL take the full 32-cycle DIVIDE path.
REQ-030 Results SHALL be bit-identical with and without the macro; only latency differs.

Verification
REQ-031 DIVU 100/7, rd=5 -> o_writeEnable one cycle at t+33, addr 5, data 14; REMU same operands -> data 2.
REQ-032 DIV -7/2 (0xFFFFFFF9, 2) -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1).
REQ-033 DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; latency t+1 with DIVIDER_FASTPATH_EN, t+33 without.
REQ-034 Second i_start pulse at t+10 during DIVIDE -> ignored, exactly one write; rd=0 op -> o_busy pulses for 33 cycles and o_writeEnable stays 0.
REQ-035 i_arst_n low at t+15 -> all outputs 0 in the same cycle, no write; new start after release completes normally.
